// File: rtl/seg_scan_mux_if.sv
// Bundle between the display scanner and its host/decoder side.
// The host loads words and sets modes; the scanner returns nibble, anodes and status.
interface seg_scan_mux_if;
    logic        load;
    logic [15:0] value_in;
    logic        lzb;
    logic        enable;
    logic [3:0]  bcd_out;
    logic [3:0]  an_n;
    logic        frame_done;
    logic        pending;

    modport master (
        output load, value_in, lzb, enable,
        input  bcd_out, an_n, frame_done, pending
    );

    modport slave (
        input  load, value_in, lzb, enable,
        output bcd_out, an_n, frame_done, pending
    );
endinterface

// File: rtl/seg_scan_mux.sv
// 4-digit multiplexed 7-segment scanner with ghost blanking, leading-zero
// suppression and a double-buffered display word committed on frame boundaries.
module seg_scan_mux #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input logic           clk,
    input logic           rst_n,
    seg_scan_mux_if.slave bus
);
    localparam int CW = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]    digit_idx_q, digit_idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   disp_q, disp_d;
    logic          pending_q, pending_d;
    logic [3:0]    bcd_q, bcd_d;
    logic [3:0]    an_n_q, an_n_d;
    logic          frame_done_q, frame_done_d;
    logic          wrap, boundary;

    function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    nibble = v[3:0];
            2'd1:    nibble = v[7:4];
            2'd2:    nibble = v[11:8];
            default: nibble = v[15:12];
        endcase
    endfunction

    // True when this digit and everything above it is zero; digit 0 always shows.
    function automatic logic leading_zero(input logic [15:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    leading_zero = 1'b0;
            2'd1:    leading_zero = (v[15:4] == 12'h000);
            2'd2:    leading_zero = (v[15:8] == 8'h00);
            default: leading_zero = (v[15:12] == 4'h0);
        endcase
    endfunction

    always_comb begin
        wrap        = (slot_cnt_q == SLOT_LAST);
        boundary    = wrap && (digit_idx_q == 2'd3);
        slot_cnt_d  = wrap ? '0 : slot_cnt_q + 1'b1;
        digit_idx_d = wrap ? digit_idx_q + 2'd1 : digit_idx_q;
        shadow_d    = shadow_q;
        disp_d      = disp_q;
        pending_d   = pending_q;

        // A load landing on the boundary goes straight to the display.
        if (boundary && bus.load) begin
            disp_d    = bus.value_in;
            shadow_d  = bus.value_in;
            pending_d = 1'b0;
        end else begin
            if (boundary && pending_q) begin
                disp_d    = shadow_q;
                pending_d = 1'b0;
            end
            if (bus.load) begin
                shadow_d  = bus.value_in;
                pending_d = 1'b1;
            end
        end

        // Outputs are computed from next-state so nibble and digit change together,
        // always inside the blank phase of the new slot.
        bcd_d  = nibble(disp_d, digit_idx_d);
        an_n_d = 4'b1111;
        if ((slot_cnt_d >= BLANK_END) && bus.enable &&
            !(bus.lzb && leading_zero(disp_d, digit_idx_d)))
            an_n_d = ~(4'b0001 << digit_idx_d);
        frame_done_d = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q   <= '0;
            digit_idx_q  <= 2'd0;
            shadow_q     <= 16'h0000;
            disp_q       <= 16'h0000;
            pending_q    <= 1'b0;
            bcd_q        <= 4'h0;
            an_n_q       <= 4'b1111;
            frame_done_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            digit_idx_q  <= digit_idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            pending_q    <= pending_d;
            bcd_q        <= bcd_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.bcd_out    = bcd_q;
    assign bus.an_n       = an_n_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = pending_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with SLOT=8, BLANK=2 (32-cycle frames).
module tb_seg_scan_mux;
    localparam int SLOT  = 8;
    localparam int BLANK = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   k     = 0;

    seg_scan_mux_if bus ();

    seg_scan_mux #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    task automatic step_to(input int target);
        while (k < target) step();
    endtask

    // One full frame from a frame_done cycle; lit[d] says whether digit d should light.
    task automatic run_frame(input logic [15:0] val, input logic [3:0] lit,
                             input int ld0, input logic [15:0] v0,
                             input int ld1, input logic [15:0] v1);
        for (int i = 0; i < 32; i++) begin
            int d;
            int s;
            logic [3:0] exp_an;
            logic exp_p;
            d      = i / 8;
            s      = i % 8;
            exp_an = (s < BLANK || !lit[d]) ? 4'b1111 : ~(4'b0001 << d);
            exp_p  = (ld0 >= 0 && ld0 < 31 && i > ld0) || (ld1 >= 0 && ld1 < 31 && i > ld1);
            chk($sformatf("an_n k=%0d", k), {12'h000, bus.an_n}, {12'h000, exp_an});
            chk($sformatf("bcd k=%0d", k), {12'h000, bus.bcd_out}, {12'h000, val[4*d +: 4]});
            chk($sformatf("frame_done k=%0d", k), {15'h0000, bus.frame_done}, {15'h0000, (i == 0)});
            chk($sformatf("pending k=%0d", k), {15'h0000, bus.pending}, {15'h0000, exp_p});
            bus.load     = (i == ld0) || (i == ld1);
            bus.value_in = (i == ld1) ? v1 : v0;
            step();
        end
        bus.load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, k=%0d", k);
        $fatal(1, "timeout");
    end

    initial begin
        bus.load     = 1'b0;
        bus.value_in = 16'h0000;
        bus.lzb      = 1'b0;
        bus.enable   = 1'b1;

        // Held in reset across clock edges
        @(negedge clk);
        @(negedge clk);
        chk("rst an_n", {12'h000, bus.an_n}, 16'h000F);
        chk("rst bcd", {12'h000, bus.bcd_out}, 16'h0000);
        chk("rst frame_done", {15'h0000, bus.frame_done}, 16'h0000);
        chk("rst pending", {15'h0000, bus.pending}, 16'h0000);
        rst_n = 1'b1;
        k     = 0;

        // Scan order with 1234
        bus.load     = 1'b1;
        bus.value_in = 16'h1234;
        step();
        bus.load = 1'b0;
        chk("pending after load", {15'h0000, bus.pending}, 16'h0001);
        step_to(32);
        run_frame(16'h1234, 4'hF, -1, 16'h0000, -1, 16'h0000);
        run_frame(16'h1234, 4'hF, -1, 16'h0000, -1, 16'h0000);

        // Double buffer: last load wins, ABCD never shown
        run_frame(16'h1234, 4'hF, 4, 16'hABCD, 14, 16'h00F0);
        run_frame(16'h00F0, 4'hF, -1, 16'h0000, -1, 16'h0000);

        // Load on the boundary cycle
        run_frame(16'h00F0, 4'hF, 31, 16'h5555, -1, 16'h0000);
        run_frame(16'h5555, 4'hF, 5, 16'h0070, -1, 16'h0000);

        // Leading-zero blanking
        bus.lzb = 1'b1;
        run_frame(16'h0070, 4'b0011, 3, 16'h0000, -1, 16'h0000);
        run_frame(16'h0000, 4'b0001, -1, 16'h0000, -1, 16'h0000);

        // Enable low for 40 cycles
        bus.lzb    = 1'b0;
        bus.enable = 1'b0;
        run_frame(16'h0000, 4'b0000, -1, 16'h0000, -1, 16'h0000);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("an_n off k=%0d", k), {12'h000, bus.an_n}, 16'h000F);
            if (j == 0) chk("frame_done off", {15'h0000, bus.frame_done}, 16'h0001);
            step();
        end
        bus.enable = 1'b1;
        step_to(352);
        run_frame(16'h0000, 4'hF, -1, 16'h0000, -1, 16'h0000);

        // Async reset mid-slot with a pending value
        bus.load     = 1'b1;
        bus.value_in = 16'h9876;
        step();
        bus.load = 1'b0;
        chk("pending before rst", {15'h0000, bus.pending}, 16'h0001);
        step_to(388);
        chk("an_n lit before rst", {12'h000, bus.an_n}, 16'h000E);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst an_n", {12'h000, bus.an_n}, 16'h000F);
        chk("async rst pending", {15'h0000, bus.pending}, 16'h0000);
        chk("async rst bcd", {12'h000, bus.bcd_out}, 16'h0000);
        @(negedge clk);
        chk("held rst an_n", {12'h000, bus.an_n}, 16'h000F);
        rst_n = 1'b1;
        k     = 0;
        step_to(32);
        run_frame(16'h0000, 4'hF, -1, 16'h0000, -1, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed scanner for a 4-digit common-anode 7-segment display showing a 16-bit machine word (AC, PC, AR, ...). It sits directly upstream of the BCD-to-7-segment decoder. It drives the decoder's 4-bit nibble input and the active-low digit anodes, with inter-digit ghost blanking and leading-zero suppression. New values are double-buffered and committed only at frame boundaries, so a display never tears.

## Interface
- SLOT_CYCLES, 50000: clock cycles per digit slot (legal: ≥ 4).
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off (legal: 1 ≤ BLANK_CYCLES < SLOT_CYCLES).
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle strobe; capture value_in into the shadow register.
- value_in  input  16  word to display; nibble k shows on digit k (digit 3 is most significant).
- lzb  input  1  leading-zero blanking enable (level, evaluated live).
- enable  input  1  0 forces all anodes off; scanning continues.
- bcd_out  output  4  nibble for the current digit; feeds the decoder input.
- an_n  output  4  digit anodes, active-low, one-hot-low when lit.
- frame_done  output  1  one-cycle pulse at each frame boundary (commit point).
- pending  output  1  shadow holds a value not yet committed.

## Operation
- Registers:
  - slot_cnt: 0..SLOT_CYCLES-1.
  - digit_idx: 0..3, scan order 0,1,2,3, then wraps to 0.
  - shadow[15:0].
  - disp[15:0].
  - pending.
- Slot counter:
  - Increments every cycle.
  - At SLOT_CYCLES-1 it wraps to 0 and digit_idx advances.
  - digit_idx wraps 3→0.
- Frame boundary: the cycle where slot_cnt = SLOT_CYCLES-1 and digit_idx = 3.
  - frame_done is registered and is high in the following cycle.
  - If pending=1 at the boundary: disp ← shadow and pending ← 0.
- Load:
  - shadow ← value_in and pending ← 1.
  - A second load before commit overwrites shadow; last load wins.
- Load on the frame-boundary cycle: value_in bypasses shadow.
  - disp ← value_in, shadow ← value_in, pending ← 0.
- bcd_out (registered):
  - Equals disp nibble digit_idx.
  - Updates in the same cycle digit_idx changes, so it is stable before the anode turns on.
- Anode phases (registered):
  - Blank phase (slot_cnt < BLANK_CYCLES): an_n = 4'b1111.
  - On phase: an_n[digit_idx] = 0 and all other bits 1, unless the digit is suppressed.
- Suppression: a digit is suppressed if any of these holds:
  - enable = 0.
  - lzb = 1, digit_idx ≠ 0, and disp nibbles digit_idx..3 are all zero.
  - Digit 0 is never suppressed by lzb.
- States (per slot): BLANK → ON → (wrap) BLANK of the next digit. There is no other state.

## Timing
- Reset values, applied asynchronously on rst_n low and held until release:
  - an_n = 4'b1111.
  - bcd_out = 0.
  - frame_done = 0.
  - pending = 0.
  - slot_cnt = 0, digit_idx = 0.
  - shadow = 0, disp = 0.
- Reset mid-scan drops the display immediately and discards any pending value.
- First cycle after release: slot 0, digit 0, blank phase.
- Frame length: 4·SLOT_CYCLES cycles.
- Anode on-time per digit: SLOT_CYCLES − BLANK_CYCLES cycles.
- Load-to-display latency:
  - Commit happens at the next frame boundary at or after the load cycle (worst case 4·SLOT_CYCLES cycles).
  - The new digits appear from the next digit-0 on phase.
- enable and lzb take effect on the next clock edge (registered an_n).
- Never more than one anode is low in any cycle.
- An anode never goes low in the same cycle as a bcd_out change.

## Test plan
- Reset and scan order, with SLOT=8, BLANK=2, load 16'h1234, then run 2 frames:
  - an_n cycles through 1110, 1101, 1011, 0111, each low 6 cycles and preceded by 2 cycles of 1111.
  - bcd_out reads 4, 3, 2, 1.
  - frame_done pulses every 32 cycles.
- Double-buffer, with SLOT=8, BLANK=2:
  - Load 16'hABCD mid-frame, then 16'h00F0 before the boundary.
  - pending = 1 until the boundary.
  - Next frame shows 0, F, 0, 0; ABCD is never displayed.
- Boundary collision, with SLOT=8, BLANK=2:
  - Load 16'h5555 exactly on the frame-boundary cycle.
  - Next frame shows 5555; pending = 0 in the following cycle.
- Leading-zero blanking, with SLOT=8, BLANK=2 and lzb = 1:
  - disp = 16'h0070: digits 2 and 3 stay dark; digits 0 and 1 light (values 0, 7).
  - disp = 16'h0000: only digit 0 lights (value 0).
- Enable and async reset, with SLOT=8, BLANK=2:
  - Drop enable for 40 cycles: an_n = 1111 throughout while frame_done keeps pulsing.
  - Assert rst_n low mid-slot between clock edges: an_n goes 1111 with no clock edge, and pending clears.
